// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register.
//
// Carries instruction, PC, PC+8, BD flag, merged exception code and an opaque
// payload bus from one pipeline stage to the next. It also provides a valid
// bit and three controls, in fixed priority order:
//   reset > req > flush > stall > load
//
// Optional feature: define PIPE_PERF_EN to get saturating bubble/stall cycle
// counters. Without it, bubble_cnt and stall_cnt are tied to zero and no
// counter flops are built.
//
// Parameters:
//   PAYLOAD_W  width of the opaque datapath bundle
//   RESET_PC   out_pc value after reset
//   EXC_PC     out_pc value after an exception request
//   CNT_W      width of the optional performance counters
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   req             exception/interrupt entry; kills the stage contents
//   flush           insert a bubble (PC and BD still captured)
//   stall           hold the current contents
//   in_*            upstream stage contents
//   stage_exc       exception raised by the upstream stage itself
//   out_*           registered stage contents
//   bubble_cnt      bubble cycles (PIPE_PERF_EN only)
//   stall_cnt       stall cycles (PIPE_PERF_EN only)
module pipe_stage_reg #(
    parameter int unsigned PAYLOAD_W = 128,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_PC    = 32'h0000_4180,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 flush,
    input  logic                 stall,
    input  logic                 in_valid,
    input  logic [31:0]          in_instr,
    input  logic [31:0]          in_pc,
    input  logic                 in_bd,
    input  logic [4:0]           in_exc,
    input  logic [4:0]           stage_exc,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    output logic [31:0]          out_instr,
    output logic [31:0]          out_pc,
    output logic [31:0]          out_pc8,
    output logic                 out_bd,
    output logic [4:0]           out_exc,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     stall_cnt
);

    logic                 valid_q, valid_d;
    logic [31:0]          instr_q, instr_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          pc8_q, pc8_d;
    logic                 bd_q, bd_d;
    logic [4:0]           exc_q, exc_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;

    // Earliest exception wins: an exception carried in from an older stage
    // takes precedence over one raised by the upstream stage.
    logic [4:0] exc_merged;
    assign exc_merged = (in_exc != 5'd0) ? in_exc : stage_exc;

    always_comb begin
        valid_d   = valid_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        pc8_d     = pc8_q;
        bd_d      = bd_q;
        exc_d     = exc_q;
        payload_d = payload_q;
        if (req) begin
            valid_d   = 1'b0;
            instr_d   = 32'd0;
            pc_d      = EXC_PC;
            pc8_d     = EXC_PC + 32'd8;
            bd_d      = 1'b0;
            exc_d     = 5'd0;
            payload_d = '0;
        end else if (flush) begin
            // Bubble still records PC/BD so CP0 sees the macroscopic PC.
            valid_d   = 1'b0;
            instr_d   = 32'd0;
            pc_d      = in_pc;
            pc8_d     = in_pc + 32'd8;
            bd_d      = in_bd;
            exc_d     = 5'd0;
            payload_d = '0;
        end else if (!stall) begin
            valid_d   = in_valid;
            // An empty slot carries neither an instruction nor an exception.
            instr_d   = in_valid ? in_instr : 32'd0;
            pc_d      = in_pc;
            pc8_d     = in_pc + 32'd8;
            bd_d      = in_bd;
            exc_d     = in_valid ? exc_merged : 5'd0;
            payload_d = in_payload;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            instr_q   <= 32'd0;
            pc_q      <= RESET_PC;
            pc8_q     <= RESET_PC + 32'd8;
            bd_q      <= 1'b0;
            exc_q     <= 5'd0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pc8_q     <= pc8_d;
            bd_q      <= bd_d;
            exc_q     <= exc_d;
            payload_q <= payload_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_instr   = instr_q;
    assign out_pc      = pc_q;
    assign out_pc8     = pc8_q;
    assign out_bd      = bd_q;
    assign out_exc     = exc_q;
    assign out_payload = payload_q;

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] bubble_q;
    logic [CNT_W-1:0] stall_q;
    logic             bubble_inc;
    logic             stall_inc;

    // Counting follows the same priority as the datapath; req counts as neither.
    assign bubble_inc = !req && flush && (bubble_q != {CNT_W{1'b1}});
    assign stall_inc  = !req && !flush && stall && (stall_q != {CNT_W{1'b1}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_q <= '0;
            stall_q  <= '0;
        end else begin
            if (bubble_inc) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
            if (stall_inc) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign bubble_cnt = bubble_q;
    assign stall_cnt  = stall_q;
`else
    assign bubble_cnt = '0;
    assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the driver applies directed vectors on
// the falling edge and queues the hand-computed register contents expected
// after the next rising edge; a monitor pops and compares them just after it.
module tb_pipe_stage_reg;

    localparam int unsigned PW = 128;
    localparam int unsigned CW = 4;
`ifdef PIPE_PERF_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req = 1'b0;
    logic          flush = 1'b0;
    logic          stall = 1'b0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_instr = '0;
    logic [31:0]   in_pc = '0;
    logic          in_bd = 1'b0;
    logic [4:0]    in_exc = '0;
    logic [4:0]    stage_exc = '0;
    logic [PW-1:0] in_payload = '0;
    logic          out_valid;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic [31:0]   out_pc8;
    logic          out_bd;
    logic [4:0]    out_exc;
    logic [PW-1:0] out_payload;
    logic [CW-1:0] bubble_cnt;
    logic [CW-1:0] stall_cnt;

    pipe_stage_reg #(
        .PAYLOAD_W(PW),
        .RESET_PC (32'h0000_3000),
        .EXC_PC   (32'h0000_4180),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .flush      (flush),
        .stall      (stall),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .in_bd      (in_bd),
        .in_exc     (in_exc),
        .stage_exc  (stage_exc),
        .in_payload (in_payload),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_pc8    (out_pc8),
        .out_bd     (out_bd),
        .out_exc    (out_exc),
        .out_payload(out_payload),
        .bubble_cnt (bubble_cnt),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [31:0]   instr;
        logic [31:0]   pc;
        logic [31:0]   pc8;
        logic          bd;
        logic [4:0]    exc;
        logic [PW-1:0] payload;
        logic [CW-1:0] bcnt;
        logic [CW-1:0] scnt;
    } exp_t;

    exp_t expq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   eb      = 0;
    int   es      = 0;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Drive one vector and queue its expected post-edge contents.
    task automatic apply(input bit rq, input bit fl, input bit st, input bit v,
                         input logic [31:0] ins, input logic [31:0] pc, input bit bd,
                         input logic [4:0] ex, input logic [4:0] sx, input logic [PW-1:0] pay,
                         input bit ev, input logic [31:0] ei, input logic [31:0] ep,
                         input logic [31:0] ep8, input bit ebd, input logic [4:0] ee,
                         input logic [PW-1:0] epay);
        exp_t e;
        @(negedge clk);
        req = rq; flush = fl; stall = st; in_valid = v; in_instr = ins; in_pc = pc;
        in_bd = bd; in_exc = ex; stage_exc = sx; in_payload = pay;
        if (!rq && fl) eb = (eb < 15) ? eb + 1 : 15;
        else if (!rq && st) es = (es < 15) ? es + 1 : 15;
        e.valid = ev; e.instr = ei; e.pc = ep; e.pc8 = ep8; e.bd = ebd; e.exc = ee;
        e.payload = epay;
        e.bcnt = Perf ? CW'(eb) : '0;
        e.scnt = Perf ? CW'(es) : '0;
        expq.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                check("valid", PW'(out_valid), PW'(e.valid));
                check("instr", PW'(out_instr), PW'(e.instr));
                check("pc", PW'(out_pc), PW'(e.pc));
                check("pc8", PW'(out_pc8), PW'(e.pc8));
                check("bd", PW'(out_bd), PW'(e.bd));
                check("exc", PW'(out_exc), PW'(e.exc));
                check("payload", out_payload, e.payload);
                check("bubble_cnt", PW'(bubble_cnt), PW'(e.bcnt));
                check("stall_cnt", PW'(stall_cnt), PW'(e.scnt));
            end
        end
    end

    initial begin : driver
        // Asynchronous reset before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("rst_pc", PW'(out_pc), PW'(32'h3000));
        check("rst_pc8", PW'(out_pc8), PW'(32'h3008));
        check("rst_valid", PW'(out_valid), PW'(0));
        check("rst_payload", out_payload, PW'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        //    rq fl st v  instr         pc            bd ex    sx    pay
        //    ev instr         pc            pc8           bd exc   payload
        apply(0, 0, 0, 1, 32'hA1, 32'h3010, 0, 5'd0, 5'd4, 128'h11,
              1, 32'hA1, 32'h3010, 32'h3018, 0, 5'd4, 128'h11);
        apply(0, 0, 0, 1, 32'hA2, 32'h3014, 0, 5'd10, 5'd4, 128'h22,
              1, 32'hA2, 32'h3014, 32'h301C, 0, 5'd10, 128'h22);
        // Three stall cycles with changing inputs: contents hold.
        apply(0, 0, 1, 1, 32'hB1, 32'h3100, 1, 5'd3, 5'd1, 128'h33,
              1, 32'hA2, 32'h3014, 32'h301C, 0, 5'd10, 128'h22);
        apply(0, 0, 1, 0, 32'hB2, 32'h3104, 0, 5'd0, 5'd2, 128'h34,
              1, 32'hA2, 32'h3014, 32'h301C, 0, 5'd10, 128'h22);
        apply(0, 0, 1, 1, 32'hB3, 32'h3108, 1, 5'd5, 5'd0, 128'h35,
              1, 32'hA2, 32'h3014, 32'h301C, 0, 5'd10, 128'h22);
        // Flush overrides stall.
        apply(0, 1, 1, 1, 32'hC1, 32'h3200, 0, 5'd7, 5'd0, 128'h44,
              0, 32'h0, 32'h3200, 32'h3208, 0, 5'd0, 128'h0);
        apply(0, 1, 0, 1, 32'hC2, 32'h3020, 1, 5'd2, 5'd3, 128'h55,
              0, 32'h0, 32'h3020, 32'h3028, 1, 5'd0, 128'h0);
        // Empty slot: no instruction or exception, PC/BD/payload still loaded.
        apply(0, 0, 0, 0, 32'hD1, 32'h3030, 1, 5'd6, 5'd1, 128'h66,
              0, 32'h0, 32'h3030, 32'h3038, 1, 5'd0, 128'h66);
        // PC+8 wraps modulo 2^32.
        apply(0, 0, 0, 1, 32'hE1, 32'hFFFF_FFFC, 0, 5'd0, 5'd0, 128'h77,
              1, 32'hE1, 32'hFFFF_FFFC, 32'h0000_0004, 0, 5'd0, 128'h77);
        // req beats flush and stall.
        apply(1, 1, 1, 1, 32'hF1, 32'h3040, 1, 5'd9, 5'd9, 128'h88,
              0, 32'h0, 32'h4180, 32'h4188, 0, 5'd0, 128'h0);
        apply(0, 0, 0, 1, 32'hF2, 32'h3044, 1, 5'd0, 5'd12, 128'h99,
              1, 32'hF2, 32'h3044, 32'h304C, 1, 5'd12, 128'h99);

        // Twenty flushes drive the bubble counter into saturation.
        for (int i = 0; i < 20; i++) begin
            logic [31:0] p;
            p = 32'h3060 + 32'(i * 4);
            apply(0, 1, 0, 1, 32'hCAFE, p, 0, 5'd1, 5'd0, 128'hAB,
                  0, 32'h0, p, p + 32'd8, 0, 5'd0, 128'h0);
        end
        // req leaves counters alone.
        apply(1, 0, 0, 1, 32'h12, 32'h3100, 0, 5'd0, 5'd0, 128'h1,
              0, 32'h0, 32'h4180, 32'h4188, 0, 5'd0, 128'h0);
        apply(0, 0, 0, 1, 32'h13, 32'h3050, 0, 5'd0, 5'd0, 128'h2,
              1, 32'h13, 32'h3050, 32'h3058, 0, 5'd0, 128'h2);

        // Reset mid-operation, between edges, clears at once.
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_valid", PW'(out_valid), PW'(0));
        check("mid_rst_instr", PW'(out_instr), PW'(0));
        check("mid_rst_pc", PW'(out_pc), PW'(32'h3000));
        check("mid_rst_pc8", PW'(out_pc8), PW'(32'h3008));
        check("mid_rst_payload", out_payload, PW'(0));
        check("mid_rst_bcnt", PW'(bubble_cnt), PW'(0));
        check("mid_rst_scnt", PW'(stall_cnt), PW'(0));
        check("queue_drained", PW'(expq.size()), PW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
